// File: rtl/oam_writer.sv
// oam_writer: write-side owner of the sprite attribute memory (OAM).
// Game-logic updates are queued in a small FIFO and committed to OAM only
// during blanking, so the object engine never scans a half-updated sprite.
module oam_writer #(
    parameter int unsigned OAM_WIDTH  = 32,
    parameter int unsigned OAM_DEPTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDX_W     = $clog2(OAM_DEPTH),
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 video_on,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic [OAM_WIDTH-1:0] wr_data,
    input  logic                 clear_req,
    input  logic [IDX_W-1:0]     oam_addr,
    output logic [OAM_WIDTH-1:0] oam_data,
    output logic [CNT_W-1:0]     pending,
    output logic                 commit_done
);

    // Reserved field [30:27] is never stored.
    localparam logic [OAM_WIDTH-1:0] RSVD_MASK = OAM_WIDTH'(32'h7800_0000);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(OAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0]     idx;
        logic [OAM_WIDTH-1:0] data;
    } upd_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;

    upd_t                 fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nx;
    logic                 fifo_empty;
    logic                 push;
    upd_t                 head;

    logic                 clear_pending;
    logic [IDX_W-1:0]     clr_cnt;

    logic                 do_pop;
    logic                 do_clr;
    logic                 clr_last;
    logic                 clr_start;
    logic                 done_nx;

    logic [OAM_WIDTH-1:0] oam [OAM_DEPTH];

    assign push       = wr_valid && wr_ready;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign count_nx   = count + CNT_W'(push) - CNT_W'(do_pop);
    assign pending    = count;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-cycle commit controls.
    always_comb begin
        state_nx  = state;
        do_pop    = 1'b0;
        do_clr    = 1'b0;
        clr_last  = 1'b0;
        clr_start = 1'b0;
        done_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!video_on) begin
                    if (clear_pending) begin
                        state_nx  = S_CLEAR;
                        clr_start = 1'b1;
                    end else if (!fifo_empty) begin
                        state_nx = S_COMMIT;
                    end
                end
            end
            S_CLEAR: begin
                // Active video pauses the sweep with the counter held.
                if (!video_on) begin
                    do_clr = 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        clr_last = 1'b1;
                        if (!fifo_empty) begin
                            state_nx = S_COMMIT;
                        end else begin
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                // The write in the cycle video_on rises still lands, then we stop.
                if (fifo_empty) begin
                    state_nx = S_IDLE;
                end else begin
                    do_pop = 1'b1;
                    if (count == CNT_W'(1)) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else if (video_on) begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Clear request flag, clear sweep counter and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
            commit_done   <= 1'b0;
        end else begin
            commit_done <= done_nx;
            if (clr_last) begin
                clear_pending <= 1'b0;
            end else if (clear_req) begin
                clear_pending <= 1'b1;
            end
            if (clr_start) begin
                clr_cnt <= '0;
            end else if (do_clr) begin
                clr_cnt <= clr_cnt + IDX_W'(1);
            end
        end
    end

    // FIFO pointers, occupancy and ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_nx;
            wr_ready <= (count_nx != FULL_CNT);
        end
    end

    // FIFO payload storage; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{idx: wr_index, data: wr_data & ~RSVD_MASK};
        end
    end

    // OAM array and registered read port (read-before-write on collision).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < OAM_DEPTH; i++) begin
                oam[i] <= '0;
            end
            oam_data <= '0;
        end else begin
            oam_data <= oam[oam_addr];
            if (do_clr) begin
                oam[clr_cnt] <= '0;
            end else if (do_pop) begin
                oam[head.idx] <= head.data;
            end
        end
    end

endmodule
